dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit sitting directly downstream of the core's M stage, between the core data port and a single-port synchronous data SRAM (1-cycle read latency).
- Core side: generates byte-lane write strobes for SB/SH/SW, aligns and sign/zero-extends LB/LH/LW/LBU/LHU results for the W stage, and flags misaligned accesses.
- Host side: a Wishbone-style port so the management SoC can preload or inspect data memory while the core is halted.

## Interface
Parameters:
- DATA_WIDTH, 32, data and byte-address width
- ADDR_WIDTH, 10, SRAM word-address width (4 KiB)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_mem_write_M  in  1  core store request (M stage)
- i_mem_read_M  in  1  core load request (M stage)
- i_funct3_M  in  3  load/store width and sign code
- i_data_addr_M  in  DATA_WIDTH  byte address
- i_write_data_M  in  DATA_WIDTH  store data, unaligned in bits [7:0]/[15:0]/[31:0]
- o_read_data_W  out  DATA_WIDTH  aligned, extended load result (W stage)
- o_misaligned  out  1  one-cycle pulse on a misaligned core access
- i_core_halt  in  1  core halted; host may own the SRAM
- i_host_req  in  1  host strobe
- i_host_we  in  1  host write
- i_host_sel  in  4  host byte selects
- i_host_addr  in  DATA_WIDTH  host byte address
- i_host_wdata  in  DATA_WIDTH  host write data
- o_host_ack  out  1  host transfer done (one cycle)
- o_host_rdata  out  DATA_WIDTH  host read data, registered
- o_sram_en  out  1  SRAM enable
- o_sram_we  out  4  SRAM byte write enables
- o_sram_addr  out  ADDR_WIDTH  SRAM word address
- o_sram_wdata  out  DATA_WIDTH  SRAM write data, lane-replicated
- i_sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after the enable

## Operation
- Word address is addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so out-of-range addresses wrap.
- Stores:
  - SB: we = 1<<addr[1:0], wdata = byte replicated ×4.
  - SH: we = 0011 or 1100 by addr[1], wdata = half replicated ×2.
  - SW: we = 1111.
- Loads: o_sram_en=1, we=0. A read-pipe register captures {valid, funct3, addr[1:0]} for one cycle.
- Load extraction in the cycle after the access:
  - LB/LBU pick byte addr[1:0]; LH/LHU pick half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 returns 0.
- Misalignment is defined as halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Store: the write is suppressed (we=0000).
  - Load: o_read_data_W = 0.
  - Both: o_misaligned pulses in the access cycle.
- If i_mem_write_M and i_mem_read_M are both high, the store wins.
- Arbitration: the core owns the SRAM unless i_core_halt=1. Core requests while halted are ignored.
- Host FSM:
  - IDLE: when i_host_req && i_core_halt, drive the SRAM with host addr, we = i_host_we ? i_host_sel : 0000, and wdata; go to RESP. A request while not halted waits in IDLE.
  - RESP: o_host_rdata <= i_sram_rdata (reads only); o_host_ack <= 1; go to DONE.
  - DONE: ack high for this one cycle; go to IDLE.
  - The host must drop req while ack is high. If req is still high in IDLE, it is a new transfer.
- The SRAM is used only in the IDLE grant cycle. If halt drops during RESP/DONE, the transfer still completes and the core's SRAM use is unaffected.

## Timing
- Core access in cycle N: SRAM outputs are combinational in N; o_read_data_W is valid during N+1 (combinational from i_sram_rdata plus the read-pipe register).
- o_misaligned is combinational in cycle N.
- Host latency: req sampled at N → ack in N+2 → earliest next grant N+3.
- Reset values:
  - FSM = IDLE.
  - o_host_ack = 0, o_host_rdata = 0.
  - Read-pipe valid = 0, so o_read_data_W = 0.
  - o_sram_en = 0, o_sram_we = 0000, o_misaligned = 0.
- Reset mid-transfer aborts it: no ack is issued, and any SRAM write already issued stands.

## Structure
- Shared package `osiris_pkg`:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - Host FSM state encoding.
- Sub-module `load_align`: combinational extract and extend from (funct3, offset, word). It is reusable by a future cache path.

## Test plan
- SW 0xDEADBEEF @0x10, then LB @0x13 → o_read_data_W=0xFFFFFFDE at N+1. LBU @0x13 → 0x000000DE.
- SH 0x1234 @0x12, then LW @0x10 → 0x1234BEEF. LHU @0x12 → 0x00001234; LH @0x10 → 0xFFFFBEEF.
- LW @0x11 → o_misaligned pulse, data 0. SH @0x13 → pulse, and a later LW @0x10 is unchanged.
- Host write 0xCAFEF00D @0x20, sel=1111, with halt=0 → no ack for 5 cycles. Raise halt → ack exactly 2 cycles after the grant; host read @0x20 → o_host_rdata=0xCAFEF00D.
- Address 0x1010 with ADDR_WIDTH=10 → wraps to word 4 (alias of 0x10).
- Assert rst during RESP → ack never asserts, all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/osiris_pkg.sv
// Shared definitions for the data-memory path: funct3 codes, host FSM states
// and the alignment rule used for core accesses.
package osiris_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    HOST_IDLE,
    HOST_RESP,
    HOST_DONE
  } host_state_t;

  // Halfword needs offset[0]==0, word needs offset==0; the low two funct3 bits
  // carry the size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word from an
// SRAM word and sign- or zero-extends it according to funct3.
module load_align
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core M stage and a 1-cycle synchronous data SRAM,
// with a Wishbone-style host port that may own the SRAM while the core is halted.
module dmem_lsu
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_write_M,
  input  logic                  i_mem_read_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [DATA_WIDTH-1:0] i_data_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic [DATA_WIDTH-1:0] o_read_data_W,
  output logic                  o_misaligned,
  input  logic                  i_core_halt,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [3:0]            i_host_sel,
  input  logic [DATA_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_ack,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic                  o_sram_en,
  output logic [3:0]            o_sram_we,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata
);

  host_state_t state_q, state_d;

  logic                  core_act, core_mis, core_store, core_load, host_grant;
  logic [3:0]            st_we;
  logic [DATA_WIDTH-1:0] st_wdata, aligned;
  logic                  host_rd_q;
  logic                  rp_valid_q;
  logic [2:0]            rp_funct3_q;
  logic [1:0]            rp_offset_q;

  // Core and host paths are gated by rst so the SRAM is idle while in reset.
  assign core_act   = !rst && !i_core_halt && (i_mem_write_M || i_mem_read_M);
  assign core_mis   = core_act && is_misaligned(i_funct3_M, i_data_addr_M[1:0]);
  assign core_store = core_act && i_mem_write_M;
  assign core_load  = core_act && !i_mem_write_M;
  assign host_grant = !rst && (state_q == HOST_IDLE) && i_host_req && i_core_halt;

  always_comb begin
    st_we    = 4'b0000;
    st_wdata = i_write_data_M;
    case (i_funct3_M)
      F3_SB: begin
        st_we    = 4'b0001 << i_data_addr_M[1:0];
        st_wdata = {4{i_write_data_M[7:0]}};
      end
      F3_SH: begin
        st_we    = i_data_addr_M[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_write_data_M[15:0]}};
      end
      F3_SW:   st_we = 4'b1111;
      default: st_we = 4'b0000;
    endcase
  end

  always_comb begin
    o_sram_en    = 1'b0;
    o_sram_we    = 4'b0000;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (host_grant) begin
      o_sram_en    = 1'b1;
      o_sram_we    = i_host_we ? i_host_sel : 4'b0000;
      o_sram_addr  = i_host_addr[ADDR_WIDTH+1:2];
      o_sram_wdata = i_host_wdata;
    end else if (core_act) begin
      o_sram_en    = 1'b1;
      o_sram_we    = (core_store && !core_mis) ? st_we : 4'b0000;
      o_sram_addr  = i_data_addr_M[ADDR_WIDTH+1:2];
      o_sram_wdata = st_wdata;
    end
  end

  assign o_misaligned = core_mis;

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOST_IDLE: if (host_grant) state_d = HOST_RESP;
      HOST_RESP: state_d = HOST_DONE;
      HOST_DONE: state_d = HOST_IDLE;
      default:   state_d = HOST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOST_IDLE;
      o_host_ack   <= 1'b0;
      o_host_rdata <= '0;
      host_rd_q    <= 1'b0;
      rp_valid_q   <= 1'b0;
      rp_funct3_q  <= '0;
      rp_offset_q  <= '0;
    end else begin
      state_q    <= state_d;
      o_host_ack <= (state_q == HOST_RESP);
      if (host_grant) host_rd_q <= !i_host_we;
      if (state_q == HOST_RESP && host_rd_q) o_host_rdata <= i_sram_rdata;
      rp_valid_q  <= core_load && !core_mis;
      rp_funct3_q <= i_funct3_M;
      rp_offset_q <= i_data_addr_M[1:0];
    end
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .funct3 (rp_funct3_q),
    .offset (rp_offset_q),
    .word   (i_sram_rdata),
    .data   (aligned)
  );

  assign o_read_data_W = rp_valid_q ? aligned : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a behavioural 1-cycle SRAM attached.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write, mem_read, core_halt;
  logic [2:0]  funct3;
  logic [31:0] data_addr, write_data, read_data_w;
  logic        misaligned;
  logic        host_req, host_we, host_ack;
  logic [3:0]  host_sel;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .i_mem_write_M(mem_write), .i_mem_read_M(mem_read), .i_funct3_M(funct3),
    .i_data_addr_M(data_addr), .i_write_data_M(write_data),
    .o_read_data_W(read_data_w), .o_misaligned(misaligned),
    .i_core_halt(core_halt), .i_host_req(host_req), .i_host_we(host_we),
    .i_host_sel(host_sel), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ack(host_ack), .o_host_rdata(host_rdata),
    .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
  );

  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_mis;
    logic [31:0] exp_rd;   // o_read_data_W expected in the following cycle
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];

  task automatic idle_core();
    mem_write = 1'b0; mem_read = 1'b0; funct3 = 3'd0;
    data_addr = '0; write_data = '0;
  endtask

  initial begin
    bit seen;
    int cyc;
    logic [31:0] exp_v;

    vecs.push_back('{1, 0, 3'd2, 32'h10,   32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{0, 1, 3'd0, 32'h13,   32'h0,        0, 32'hFFFFFFDE});
    vecs.push_back('{0, 1, 3'd4, 32'h13,   32'h0,        0, 32'h000000DE});
    vecs.push_back('{1, 0, 3'd1, 32'h12,   32'hAAAA1234, 0, 32'h0});
    vecs.push_back('{0, 1, 3'd2, 32'h10,   32'h0,        0, 32'h1234BEEF});
    vecs.push_back('{0, 1, 3'd5, 32'h12,   32'h0,        0, 32'h00001234});
    vecs.push_back('{0, 1, 3'd1, 32'h10,   32'h0,        0, 32'hFFFFBEEF});
    vecs.push_back('{0, 1, 3'd2, 32'h11,   32'h0,        1, 32'h0});
    vecs.push_back('{1, 0, 3'd1, 32'h13,   32'h00005555, 1, 32'h0});
    vecs.push_back('{0, 1, 3'd2, 32'h10,   32'h0,        0, 32'h1234BEEF});
    vecs.push_back('{0, 1, 3'd2, 32'h1010, 32'h0,        0, 32'h1234BEEF});
    vecs.push_back('{1, 0, 3'd0, 32'h1011, 32'hFFFFFF77, 0, 32'h0});
    vecs.push_back('{0, 1, 3'd4, 32'h11,   32'h0,        0, 32'h00000077});
    vecs.push_back('{0, 1, 3'd0, 32'h11,   32'h0,        0, 32'h00000077});
    vecs.push_back('{0, 1, 3'd2, 32'h10,   32'h0,        0, 32'h123477EF});
    vecs.push_back('{1, 1, 3'd2, 32'h14,   32'h01020304, 0, 32'h0});
    vecs.push_back('{0, 1, 3'd2, 32'h14,   32'h0,        0, 32'h01020304});
    vecs.push_back('{0, 1, 3'd3, 32'h14,   32'h0,        0, 32'h0});
    vecs.push_back('{0, 1, 3'd5, 32'h16,   32'h0,        0, 32'h00000102});
    vecs.push_back('{0, 1, 3'd0, 32'h14,   32'h0,        0, 32'h00000004});
    vecs.push_back('{0, 1, 3'd1, 32'h11,   32'h0,        1, 32'h0});

    // Reset with a misaligned store asserted: everything must stay quiet.
    rst = 1'b1; core_halt = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_sel = 4'h0; host_addr = '0; host_wdata = '0;
    mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'd2; data_addr = 32'h11; write_data = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_en", {31'b0, sram_en}, 32'h0);
    chk("rst_sram_we", {28'b0, sram_we}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    chk("rst_read_data_w", read_data_w, 32'h0);
    chk("rst_host_ack", {31'b0, host_ack}, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_core();

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      mem_write  = vecs[i].we;
      mem_read   = vecs[i].re;
      funct3     = vecs[i].f3;
      data_addr  = vecs[i].addr;
      write_data = vecs[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        chk($sformatf("vec%0d_read_data_prev", i), read_data_w, exp_v);
      end
      sb_q.push_back(vecs[i].exp_rd);
    end
    @(posedge clk); #1;
    idle_core();
    @(negedge clk);
    exp_v = sb_q.pop_front();
    chk("last_read_data", read_data_w, exp_v);

    // Host write while the core runs must wait.
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_sel = 4'hF;
    host_addr = 32'h20; host_wdata = 32'hCAFEF00D;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (host_ack || (sram_en && sram_addr == 10'd8)) seen = 1'b1;
    end
    chk("host_wait_not_halted", {31'b0, seen}, 32'h0);
    @(posedge clk); #1;
    core_halt = 1'b1;
    @(negedge clk);
    chk("host_grant_en", {31'b0, sram_en}, 32'h1);
    chk("host_grant_we", {28'b0, sram_we}, 32'hF);
    chk("host_grant_addr", {22'b0, sram_addr}, 32'h8);
    chk("host_grant_wdata", sram_wdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("host_ack_n1", {31'b0, host_ack}, 32'h0);
    @(negedge clk);
    chk("host_ack_n2", {31'b0, host_ack}, 32'h1);
    host_req = 1'b0;
    @(negedge clk);
    chk("host_ack_n3", {31'b0, host_ack}, 32'h0);

    // Core requests are ignored while halted.
    mem_write = 1'b1; funct3 = 3'd2; data_addr = 32'h20; write_data = 32'h0BAD0BAD;
    @(negedge clk);
    chk("halted_core_en", {31'b0, sram_en}, 32'h0);
    idle_core();

    // Host read back.
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_sel = 4'h0; host_addr = 32'h20;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!host_ack && cyc < 10);
    chk("host_read_ack_timeout", {31'b0, host_ack}, 32'h1);
    chk("host_read_latency", cyc, 32'd3);
    chk("host_rdata", host_rdata, 32'hCAFEF00D);
    host_req = 1'b0;

    // Core sees the host-written word once released.
    @(posedge clk); #1;
    core_halt = 1'b0;
    mem_read = 1'b1; funct3 = 3'd2; data_addr = 32'h20;
    @(posedge clk); #1;
    idle_core();
    @(negedge clk);
    chk("core_reads_host_word", read_data_w, 32'hCAFEF00D);

    // Reset during RESP aborts the transfer.
    @(posedge clk); #1;
    core_halt = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h14;
    @(posedge clk); #1;
    rst = 1'b1;
    host_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_resp_ack", {31'b0, host_ack}, 32'h0);
    chk("rst_resp_rdata", host_rdata, 32'h0);
    chk("rst_resp_sram_en", {31'b0, sram_en}, 32'h0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (host_ack) seen = 1'b1;
    end
    chk("rst_resp_no_late_ack", {31'b0, seen}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
